// File: rtl/row_fifo_write_arbiter_if.sv
// row_fifo_write_arbiter_if: producer and row-FIFO signals of the write arbiter; stat_rows exists only with ROW_ARB_STATS_EN
interface row_fifo_write_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ROW_SIZE = 3,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0][ROW_SIZE-1:0][WIDTH-1:0] req_data;
  logic fifo_full;
  logic fifo_we;
  logic [ROW_SIZE-1:0][WIDTH-1:0] fifo_data;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic busy;
`ifdef ROW_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_rows;
  modport master (
    input req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_we, fifo_data, grant_id, busy, stat_rows
  );
  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input req_ready, fifo_we, fifo_data, grant_id, busy, stat_rows
  );
`else
  modport master (
    input req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_we, fifo_data, grant_id, busy
  );
  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input req_ready, fifo_we, fifo_data, grant_id, busy
  );
`endif
endinterface

// File: rtl/row_fifo_write_arbiter.sv
// row_fifo_write_arbiter: round-robin burst arbiter sharing one row FIFO write port; ROW_ARB_STATS_EN adds per-requester row counters
module row_fifo_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int ROW_SIZE = 3,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 4
) (
  input logic clock,
  input logic reset_n,
  row_fifo_write_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_winner;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [BW-1:0] beats;
  logic own;
  logic xfer;
  // gating with reset_n keeps a reset cycle from writing a row of an abandoned packet
  assign own = state == OWN && reset_n;
  assign xfer = own && bus.req_valid[grant] && !bus.fifo_full;
  assign bus.req_ready = own && !bus.fifo_full ? NUM_REQ'(1) << grant : '0;
  assign bus.fifo_we = xfer;
  assign bus.fifo_data = own ? bus.req_data[grant] : '0;
  assign bus.grant_id = grant;
  assign bus.busy = state == OWN;
  // scan from the farthest candidate down so the nearest valid one after last_winner wins
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_winner) + k) % NUM_REQ);
      if (bus.req_valid[cand]) pick = cand;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_winner <= IW'(NUM_REQ - 1);
      beats <= '0;
    end else if (state == IDLE) begin
      if (|bus.req_valid) begin
        state <= OWN;
        grant <= pick;
        beats <= '0;
      end
    end else if (xfer) begin
      beats <= beats + 1'b1;
      if (bus.req_last[grant] || beats == BW'(MAX_BURST - 1)) begin
        state <= IDLE;
        last_winner <= grant;
      end
    end
  end
`ifdef ROW_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat;
  always_ff @(posedge clock) begin
    if (!reset_n) stat <= '0;
    else if (xfer && stat[grant] != 16'hFFFF) stat[grant] <= stat[grant] + 16'd1;
  end
  assign bus.stat_rows = stat;
`endif
endmodule

// File: tb/tb_row_fifo_write_arbiter.sv
// tb_row_fifo_write_arbiter: directed scenarios plus randomized traffic against a transaction-level arbitration model
module tb_row_fifo_write_arbiter;
  localparam int WIDTH = 32;
  localparam int ROW_SIZE = 3;
  localparam int NUM_REQ = 4;
  localparam int MAX_BURST = 4;
  localparam int IW = $clog2(NUM_REQ);
  typedef logic [ROW_SIZE-1:0][WIDTH-1:0] row_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  row_fifo_write_arbiter_if #(.WIDTH(WIDTH), .ROW_SIZE(ROW_SIZE), .NUM_REQ(NUM_REQ)) b ();
  row_fifo_write_arbiter #(.WIDTH(WIDTH), .ROW_SIZE(ROW_SIZE), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(b)
  );

  int tests = 0;
  int fails = 0;
  int m_owner, m_lw, m_gid, m_rows;
  int m_stat[NUM_REQ];
  logic [NUM_REQ-1:0] acc;
  row_t cur[NUM_REQ];
  logic [NUM_REQ-1:0] cur_last;
  int seqn[NUM_REQ];

  function automatic row_t mk(int r, int s);
    row_t x;
    for (int k = 0; k < ROW_SIZE; k++) x[k] = {8'(r), 8'(s), 16'(k + 1)};
    return x;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_ready();
    return (reset_n && m_owner >= 0 && !b.fifo_full) ? NUM_REQ'(1) << m_owner : '0;
  endfunction

  function automatic logic exp_we();
    return reset_n && m_owner >= 0 && b.req_valid[m_owner] && !b.fifo_full;
  endfunction

  // arbitration rules applied once per rising edge to the inputs present at that edge
  task automatic model();
    acc = exp_ready() & b.req_valid;
    if (!reset_n) begin
      m_owner = -1;
      m_gid = 0;
      m_lw = NUM_REQ - 1;
      m_rows = 0;
      for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_lw + k) % NUM_REQ;
        if (b.req_valid[c]) begin
          m_owner = c;
          m_gid = c;
          m_rows = 0;
          break;
        end
      end
    end else if (acc != '0) begin
      if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
      m_rows++;
      if (b.req_last[m_owner] || m_rows == MAX_BURST) begin
        m_lw = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model();
    #1;
  endtask

  task automatic drive(logic [NUM_REQ-1:0] en);
    b.req_valid = en;
    for (int i = 0; i < NUM_REQ; i++) begin
      b.req_data[i] = cur[i];
      b.req_last[i] = cur_last[i];
    end
  endtask

  task automatic advance(int last_pct);
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) begin
        seqn[i]++;
        cur[i] = mk(i, seqn[i]);
        cur_last[i] = $urandom_range(99) < last_pct;
      end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    b.req_valid = '0;
    b.fifo_full = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      seqn[i] = 0;
      cur[i] = mk(i, 0);
    end
    cur_last = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b.fifo_full = 1'b0;
    b.req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clock);
      tests++;
      if ({b.req_ready, b.fifo_we, b.busy, b.grant_id} !== '0) begin
        fails++;
        $display("FAIL reset c=%0d ready=%b we=%b busy=%b gid=%0d want all 0", c, b.req_ready, b.fifo_we, b.busy, b.grant_id);
      end
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    drive(4'b0100);
    @(negedge clock);
    tests++;
    if ({b.fifo_we, b.busy} !== 2'b00) begin
      fails++;
      $display("FAIL single_idle we=%b busy=%b want 0 0", b.fifo_we, b.busy);
    end
    tick();
    for (int r = 0; r < 3; r++) begin
      cur[2] = mk(2, r);
      cur_last[2] = r == 2;
      drive(4'b0100);
      @(negedge clock);
      tests++;
      if (b.fifo_we !== 1'b1 || b.fifo_data !== mk(2, r) || b.grant_id !== IW'(2)) begin
        fails++;
        $display("FAIL single_row%0d we=%b data=%h gid=%0d want 1 %h 2", r, b.fifo_we, b.fifo_data, b.grant_id, mk(2, r));
      end
      tick();
    end
    drive(4'b0000);
    @(negedge clock);
    tests++;
    if ({b.fifo_we, b.busy} !== 2'b00) begin
      fails++;
      $display("FAIL single_release we=%b busy=%b want 0 0", b.fifo_we, b.busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cur_last = '1;
    for (int c = 0; c < 10; c++) begin
      drive('1);
      @(negedge clock);
      tests++;
      if ({b.fifo_we, b.busy} !== {2{c[0]}} || (c[0] && b.grant_id !== IW'((c / 2) % NUM_REQ))) begin
        fails++;
        $display("FAIL rr c=%0d we=%b busy=%b gid=%0d want %b %b %0d", c, b.fifo_we, b.busy, b.grant_id, c[0], c[0], (c / 2) % NUM_REQ);
      end
      tick();
    end
  endtask

  task automatic test_burst_limit();
    int exp_r[7] = '{1, 1, 1, 1, 3, 1, 1};
    int exp_s[7] = '{0, 1, 2, 3, 0, 4, 5};
    int rec_r[$];
    row_t rec_d[$];
    logic [NUM_REQ-1:0] en;
    do_reset();
    cur_last[3] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      en = '0;
      en[1] = seqn[1] < 6;
      en[3] = seqn[3] < 1;
      drive(en);
      @(negedge clock);
      if (b.fifo_we === 1'b1) begin
        rec_r.push_back(int'(b.grant_id));
        rec_d.push_back(b.fifo_data);
      end
      tick();
      advance(0);
    end
    tests++;
    if (rec_r.size() != 7) begin
      fails++;
      $display("FAIL burst_count got %0d writes want 7", rec_r.size());
    end
    for (int k = 0; k < 7 && k < rec_r.size(); k++) begin
      tests++;
      if (rec_r[k] != exp_r[k] || rec_d[k] !== mk(exp_r[k], exp_s[k])) begin
        fails++;
        $display("FAIL burst_w%0d got req %0d data %h want req %0d data %h", k, rec_r[k], rec_d[k], exp_r[k], mk(exp_r[k], exp_s[k]));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    b.fifo_full = 1'b1;
    drive(4'b0001);
    @(negedge clock);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001);
      @(negedge clock);
      tests++;
      if (b.fifo_we !== 1'b0 || b.req_ready !== 4'b0000 || b.busy !== 1'b1) begin
        fails++;
        $display("FAIL full_stall c=%0d we=%b ready=%b busy=%b want 0 0000 1", c, b.fifo_we, b.req_ready, b.busy);
      end
      tick();
    end
    b.fifo_full = 1'b0;
    for (int r = 0; r < MAX_BURST; r++) begin
      drive(4'b0001);
      @(negedge clock);
      tests++;
      if (b.fifo_we !== 1'b1 || b.fifo_data !== mk(0, r) || b.req_ready !== 4'b0001) begin
        fails++;
        $display("FAIL full_row%0d we=%b data=%h ready=%b want 1 %h 0001", r, b.fifo_we, b.fifo_data, b.req_ready, mk(0, r));
      end
      tick();
      advance(0);
    end
    drive(4'b0001);
    @(negedge clock);
    tests++;
    if (b.busy !== 1'b0 || b.fifo_we !== 1'b0) begin
      fails++;
      $display("FAIL full_release busy=%b we=%b want 0 0", b.busy, b.fifo_we);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(4'b0100);
    @(negedge clock);
    tick();
    drive(4'b0100);
    @(negedge clock);
    tests++;
    if (b.fifo_we !== 1'b1) begin
      fails++;
      $display("FAIL midrst_beat1 we=%b want 1", b.fifo_we);
    end
    tick();
    advance(0);
    reset_n = 1'b0;
    drive(4'b0100);
    @(negedge clock);
    tests++;
    if (b.fifo_we !== 1'b0 || b.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_nowrite we=%b ready=%b want 0 0000", b.fifo_we, b.req_ready);
    end
    tick();
    reset_n = 1'b1;
    drive(4'b0101);
    @(negedge clock);
    tests++;
    if (b.busy !== 1'b0 || b.fifo_we !== 1'b0 || b.grant_id !== IW'(0)) begin
      fails++;
      $display("FAIL midrst_idle busy=%b we=%b gid=%0d want 0 0 0", b.busy, b.fifo_we, b.grant_id);
    end
`ifdef ROW_ARB_STATS_EN
    tests++;
    if (b.stat_rows !== '0) begin
      fails++;
      $display("FAIL midrst_stats got %h want 0", b.stat_rows);
    end
`endif
    tick();
    drive(4'b0101);
    @(negedge clock);
    tests++;
    if (b.busy !== 1'b1 || b.grant_id !== IW'(0)) begin
      fails++;
      $display("FAIL midrst_regrant busy=%b gid=%0d want 1 0", b.busy, b.grant_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] en;
    logic [NUM_REQ+IW+1:0] obs, exp;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset_n = $urandom_range(99) != 0;
      b.fifo_full = $urandom_range(3) == 0;
      for (int i = 0; i < NUM_REQ; i++) en[i] = $urandom_range(3) != 0;
      drive(en);
      @(negedge clock);
      obs = {b.req_ready, b.fifo_we, b.busy, b.grant_id};
      exp = {exp_ready(), exp_we(), m_owner >= 0, IW'(m_gid)};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL rand_ctl c=%0d ready/we/busy/gid got %b want %b", c, obs, exp);
      end
      if (exp_we()) begin
        tests++;
        if (b.fifo_data !== cur[m_owner]) begin
          fails++;
          $display("FAIL rand_data c=%0d got %h want %h", c, b.fifo_data, cur[m_owner]);
        end
      end
      tick();
      advance(30);
    end
    reset_n = 1'b1;
`ifdef ROW_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      tests++;
      if (b.stat_rows[i] !== 16'(m_stat[i])) begin
        fails++;
        $display("FAIL rand_stat%0d got %0d want %0d", i, b.stat_rows[i], m_stat[i]);
      end
    end
`endif
  endtask

  initial begin
    b.req_valid = '0;
    b.req_last = '0;
    b.req_data = '0;
    b.fifo_full = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
